// File: rtl/stopwatch_control.sv
// stopwatch_control: key debounce and start/stop/lap/clear control for the
// three-digit BCD stopwatch. Drives count enable, counter clear and display
// freeze for the counter chain.
//
// Build option: define STOPWATCH_AUTOSTOP_EN to make the counter chain's max
// flag stop the stopwatch in DONE. Without it, max is ignored, DONE is never
// entered and the counter rolls over while running.
module stopwatch_control #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       CLOCK_50,
  input  logic       aclr,
  input  logic       key_start_n,
  input  logic       key_lap_n,
  input  logic       max,
  output logic       enable,
  output logic       clr_n,
  output logic       lap_hold,
  output logic [2:0] state
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    LAP   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Bit 0 is the start/stop key, bit 1 is the lap/clear key.
  logic [1:0]    keys;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    stable_q, stablePrev_q;
  logic [1:0]    press_q;
  logic [CW-1:0] cnt_q [2];

  logic   startPress, lapPress, maxHit;
  state_e state_q, state_d;
  logic   clear_d;
  logic   enable_q, lapHold_q, clrN_q;

  assign keys       = {key_lap_n, key_start_n};
  assign startPress = press_q[0];
  assign lapPress   = press_q[1];

`ifdef STOPWATCH_AUTOSTOP_EN
  assign maxHit = max;
`else
  logic unusedMax;
  assign unusedMax = max;
  assign maxHit    = 1'b0;
`endif

  // Bring the asynchronous keys into the clock domain; idle level is high.
  always_ff @(posedge CLOCK_50 or negedge aclr) begin
    if (!aclr) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= keys;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new key level only after it has differed from the stable level for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge CLOCK_50 or negedge aclr) begin
    if (!aclr) begin
      stable_q <= 2'b11;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          stable_q[i] <= sync2_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // One-cycle press pulse on each debounced high-to-low transition; releases are ignored.
  always_ff @(posedge CLOCK_50 or negedge aclr) begin
    if (!aclr) begin
      stablePrev_q <= 2'b11;
      press_q      <= 2'b00;
    end else begin
      stablePrev_q <= stable_q;
      press_q      <= stablePrev_q & ~stable_q;
    end
  end

  // Next-state decode: max beats any press while counting, and start beats lap.
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (startPress) state_d = RUN;
      end
      RUN: begin
        if (maxHit)          state_d = DONE;
        else if (startPress) state_d = PAUSE;
        else if (lapPress)   state_d = LAP;
      end
      LAP: begin
        if (maxHit)          state_d = DONE;
        else if (startPress) state_d = PAUSE;
        else if (lapPress)   state_d = RUN;
      end
      PAUSE: begin
        if (startPress) begin
          state_d = RUN;
        end else if (lapPress) begin
          state_d = IDLE;
          clear_d = 1'b1;
        end
      end
      DONE: begin
        if (lapPress) begin
          state_d = IDLE;
          clear_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with outputs decoded from the next state so they all change on the same edge.
  always_ff @(posedge CLOCK_50 or negedge aclr) begin
    if (!aclr) begin
      state_q   <= IDLE;
      enable_q  <= 1'b0;
      lapHold_q <= 1'b0;
      clrN_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      enable_q  <= (state_d == RUN) || (state_d == LAP);
      lapHold_q <= (state_d == LAP);
      clrN_q    <= ~clear_d;
    end
  end

  assign enable   = enable_q;
  assign lap_hold = lapHold_q;
  assign clr_n    = clrN_q;
  assign state    = state_q;

endmodule

// File: tb/tb_stopwatch_control.sv
// tb_stopwatch_control: scoreboard bench for stopwatch_control with
// DEBOUNCE_CYCLES=4, so a held key reaches the outputs 8 edges after the
// first edge that samples it low.
module tb_stopwatch_control;

  logic       CLOCK_50 = 1'b0;
  logic       aclr;
  logic       key_start_n;
  logic       key_lap_n;
  logic       max;
  logic       enable;
  logic       clr_n;
  logic       lap_hold;
  logic [2:0] state;

  // Observed vector packed as {state, enable, lap_hold, clr_n}.
  logic [5:0] obs;
  logic [5:0] exp;
  logic [5:0] sb[$];

  int vectors    = 0;
  int miscompares = 0;

  localparam logic [5:0] IDLE_E  = 6'b000_0_0_1;
  localparam logic [5:0] CLR_E   = 6'b000_0_0_0;
  localparam logic [5:0] RUN_E   = 6'b001_1_0_1;
  localparam logic [5:0] LAP_E   = 6'b010_1_1_1;
  localparam logic [5:0] PAUSE_E = 6'b011_0_0_1;
  localparam logic [5:0] DONE_E  = 6'b100_0_0_1;

  assign obs = {state, enable, lap_hold, clr_n};

  stopwatch_control #(.DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50    (CLOCK_50),
    .aclr        (aclr),
    .key_start_n (key_start_n),
    .key_lap_n   (key_lap_n),
    .max         (max),
    .enable      (enable),
    .clr_n       (clr_n),
    .lap_hold    (lap_hold),
    .state       (state)
  );

  // 10 ns clock period.
  always #5 CLOCK_50 = ~CLOCK_50;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic test_reset;
    sb.push_back(RUN_E);
    sb.push_back(IDLE_E);
    key_start_n = 1'b0;
    tick(10);
    key_start_n = 1'b1;
    tick(10);
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL reset_prerun: got %b want %b", obs, exp); end
    #3 aclr = 1'b0;
    #1;
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL reset_async: got %b want %b", obs, exp); end
    tick(2);
    aclr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(IDLE_E);
      tick(10);
      exp = sb.pop_front(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL reset_idle%0d: got %b want %b", i, obs, exp); end
    end
  endtask

  task automatic test_start_stop;
    sb.push_back(IDLE_E);
    sb.push_back(RUN_E);
    sb.push_back(RUN_E);
    key_start_n = 1'b0;
    tick(7);
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL start_edge7: got %b want %b", obs, exp); end
    tick(1);
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL start_edge8: got %b want %b", obs, exp); end
    tick(2);
    key_start_n = 1'b1;
    tick(10);
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL start_held_once: got %b want %b", obs, exp); end
    sb.push_back(PAUSE_E);
    key_start_n = 1'b0;
    tick(8);
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL stop_pause: got %b want %b", obs, exp); end
    key_start_n = 1'b1;
    tick(10);
  endtask

  task automatic test_clear;
    sb.push_back(CLR_E);
    sb.push_back(IDLE_E);
    key_lap_n = 1'b0;
    tick(8);
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL clear_pulse: got %b want %b", obs, exp); end
    tick(1);
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL clear_release: got %b want %b", obs, exp); end
    key_lap_n = 1'b1;
    tick(10);
    sb.push_back(RUN_E);
    key_start_n = 1'b0;
    tick(8);
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL restart_run: got %b want %b", obs, exp); end
    key_start_n = 1'b1;
    tick(10);
  endtask

  task automatic test_bounce;
    sb.push_back(RUN_E);
    for (int i = 0; i < 5; i++) begin
      key_lap_n = 1'b0;
      tick(3);
      key_lap_n = 1'b1;
      tick(1);
    end
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL bounce_reject: got %b want %b", obs, exp); end
    sb.push_back(RUN_E);
    sb.push_back(LAP_E);
    key_lap_n = 1'b0;
    tick(6);
    key_lap_n = 1'b1;
    tick(1);
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL lap_edge7: got %b want %b", obs, exp); end
    tick(1);
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL lap_enter: got %b want %b", obs, exp); end
    tick(10);
    sb.push_back(RUN_E);
    key_lap_n = 1'b0;
    tick(8);
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL lap_return: got %b want %b", obs, exp); end
    key_lap_n = 1'b1;
    tick(10);
  endtask

  task automatic test_back_to_back;
    sb.push_back(RUN_E);
    sb.push_back(PAUSE_E);
    sb.push_back(PAUSE_E);
    key_start_n = 1'b0;
    key_lap_n   = 1'b0;
    tick(7);
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL both_edge7: got %b want %b", obs, exp); end
    tick(1);
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL both_start_wins: got %b want %b", obs, exp); end
    key_start_n = 1'b1;
    key_lap_n   = 1'b1;
    tick(10);
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL both_lap_dropped: got %b want %b", obs, exp); end
    sb.push_back(RUN_E);
    key_start_n = 1'b0;
    tick(8);
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL resume_run: got %b want %b", obs, exp); end
    key_start_n = 1'b1;
    tick(10);
  endtask

  task automatic test_autostop;
`ifdef STOPWATCH_AUTOSTOP_EN
    sb.push_back(DONE_E);
`else
    sb.push_back(PAUSE_E);
`endif
    key_start_n = 1'b0;
    tick(7);
    max = 1'b1;
    tick(1);
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL max_vs_start: got %b want %b", obs, exp); end
    max = 1'b0;
    key_start_n = 1'b1;
    tick(10);
`ifdef STOPWATCH_AUTOSTOP_EN
    sb.push_back(DONE_E);
    key_start_n = 1'b0;
    tick(8);
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL done_start_ignored: got %b want %b", obs, exp); end
    key_start_n = 1'b1;
    tick(10);
    sb.push_back(CLR_E);
    sb.push_back(IDLE_E);
    key_lap_n = 1'b0;
    tick(8);
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL done_clear: got %b want %b", obs, exp); end
    tick(1);
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL done_idle: got %b want %b", obs, exp); end
    key_lap_n = 1'b1;
    tick(10);
`else
    sb.push_back(RUN_E);
    sb.push_back(RUN_E);
    key_start_n = 1'b0;
    tick(8);
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL noauto_run: got %b want %b", obs, exp); end
    key_start_n = 1'b1;
    max = 1'b1;
    tick(3);
    exp = sb.pop_front(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL noauto_max_ignored: got %b want %b", obs, exp); end
    max = 1'b0;
    tick(10);
`endif
  endtask

  initial begin
    aclr        = 1'b0;
    key_start_n = 1'b1;
    key_lap_n   = 1'b1;
    max         = 1'b0;
    tick(3);
    aclr = 1'b1;
    tick(2);
    test_reset;
    test_start_stop;
    test_clear;
    test_bounce;
    test_back_to_back;
    test_autostop;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stopwatch_control.md
# stopwatch_control

Control front end for the three-digit BCD stopwatch: debounces two active-low push buttons, runs the start/stop/lap/clear state machine, and drives the count-enable, counter-clear and display-freeze lines of the BCD counter chain. It consumes the counter chain's `max` flag so that the stopwatch stops at 999. It sits between the board keys and the counter; the display latch downstream uses `lap_hold`.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles a key must hold before a level change is accepted (20 ms at 50 MHz); minimum 1.

Ports:
- `CLOCK_50`  in  1  system clock, 50 MHz.
- `aclr`  in  1  asynchronous active-low reset.
- `key_start_n`  in  1  start/stop button, active-low, asynchronous to the clock.
- `key_lap_n`  in  1  lap/clear button, active-low, asynchronous to the clock.
- `max`  in  1  terminal-count flag from the counter chain, level.
- `enable`  out  1  count enable to the counter chain.
- `clr_n`  out  1  active-low single-cycle counter clear.
- `lap_hold`  out  1  freeze request to the display latch.
- `state`  out  3  current FSM state: IDLE=0, RUN=1, LAP=2, PAUSE=3, DONE=4.

## Operation

- Each key is synchronised through a 2-flop synchroniser, then goes through its own debouncer: a stable level register (reset 1) and a counter. The counter clears whenever the synced input equals the stable level. The stable level takes the new value once the synced input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
- A press is a one-cycle pulse generated on the stable-level 1→0 transition. Releases generate nothing.
- FSM transitions (`start` and `lap` are the press pulses):
  - IDLE: `start` → RUN. `lap` is ignored.
  - RUN: `start` → PAUSE; `lap` → LAP; `max` → DONE.
  - LAP: `start` → PAUSE; `lap` → RUN; `max` → DONE.
  - PAUSE: `start` → RUN; `lap` → IDLE with a clear.
  - DONE: `lap` → IDLE with a clear. `start` is ignored.
- Simultaneous `start` and `lap` in one cycle: `start` wins and `lap` is discarded.
- In RUN and LAP, `max` has priority over any press in the same cycle.
- Output decode:
  - `enable`=1 in RUN and LAP only.
  - `lap_hold`=1 in LAP only.
  - `clr_n`=0 for exactly the first cycle spent in IDLE after a clear transition, and 1 otherwise.
  - `state` reflects the state register.
- Reset (async, any time, including mid-debounce or mid-clear):
  - state=IDLE, `enable`=0, `lap_hold`=0, `clr_n`=1.
  - Debounce counters are 0, stable levels are 1, synchronisers are 1, and no press pulse is pending.

## Timing

- All outputs are registered and change together on the clock edge that loads the new state; there are no combinational paths from inputs to outputs.
- Key-to-output latency, from the first edge sampling a key low (with the key held low):
  - 2 cycles of synchroniser, then DEBOUNCE_CYCLES cycles of debounce, then 1 cycle for the press pulse, then 1 cycle for the state/output update.
  - Total: DEBOUNCE_CYCLES+4 edges.
- `max` is sampled directly (it is already synchronous). Latency is 1 cycle: outputs update on the edge after `max` is first seen high.
- Glitches shorter than DEBOUNCE_CYCLES cycles, in either direction, never change the stable level.
- A key held low produces one press only. A new press requires a debounced release followed by a debounced press.

## Configuration

- `STOPWATCH_AUTOSTOP_EN` defined: the `max` transitions to DONE are active, as described above.
- `STOPWATCH_AUTOSTOP_EN` undefined:
  - The `max` input is ignored, the DONE state is unreachable, and the counter rolls over 999→000 while running.
  - The `state` encoding is unchanged.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4.

- Reset then idle: assert `aclr`=0 mid-sim → `state`=0, `enable`=0, `clr_n`=1, `lap_hold`=0 immediately; nothing changes over 50 idle cycles.
- Start/stop: hold `key_start_n` low for 10 cycles → `state`=1 and `enable`=1 exactly 8 edges after the first low sample. Release, then press again → `state`=3, `enable`=0.
- Bounce rejection: toggle `key_lap_n` low 3 cycles and high 1 cycle, repeated 5 times, while in RUN → `state` stays 1. Then hold it low 6 cycles → `state`=2, `lap_hold`=1, `enable`=1.
- Clear: from PAUSE, press lap → `state`=0 and `clr_n`=0 for exactly 1 cycle, then `clr_n`=1.
- Simultaneous presses: in RUN, align both debounced presses to the same cycle → `state`=3, no LAP entry.
- Autostop: with the macro defined, in RUN raise `max` → next edge `state`=4 and `enable`=0; start is ignored; lap clears to IDLE. With the macro undefined, `max` leaves `state`=1.
